// File: rtl/bypass_responder.sv
// Uncached (bypass) request responder: accepts one request from the cache controller,
// performs a single 64-bit memory access and returns exactly one response pulse.
package std_cache_pkg;
  typedef enum logic [3:0] {
    AMO_NONE = 4'd0, AMO_ADD, AMO_SWAP, AMO_AND, AMO_OR, AMO_XOR, AMO_MAX, AMO_MIN
  } amo_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [7:0]  be;
    logic [1:0]  size;
    logic [3:0]  id;
    amo_t        amo;
    logic [63:0] addr;
    logic [63:0] wdata;
  } bypass_req_t;

  typedef struct packed {
    logic        gnt;
    logic        valid;
    logic [63:0] rdata;
  } bypass_rsp_t;

  typedef enum logic [1:0] {BR_IDLE, BR_ISSUE, BR_WAIT, BR_RESP} br_state_e;

  typedef struct packed {
    br_state_e  state;
    logic [3:0] id;
  } br_dbg_t;
endpackage

// Handshakes: requester side is req/gnt (gnt only while IDLE, same cycle as req) and a
// one-cycle valid pulse; memory side holds mem_req_o and its fields until mem_gnt_i, then
// expects exactly one mem_rvalid_i, which is only honoured while waiting for it.
module bypass_responder
  import std_cache_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  bypass_req_t bypass_req_i,
  output bypass_rsp_t bypass_rsp_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [63:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [63:0] mem_wdata_o,
  output logic [7:0]  mem_be_o,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i,
  output logic        err_o,
  output br_dbg_t     dbg_o
);

  localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;
  localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

  br_state_e   state_q, state_d;
  logic [63:0] addr_q, wdata_q, rdata_q, rdata_d;
  logic        we_q;
  logic [7:0]  be_q;
  logic [1:0]  size_q;
  logic [3:0]  id_q;
  amo_t        amo_q;
  logic        err_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic gnt, capture, set_err, reject, timeout;

  assign reject  = (amo_q != AMO_NONE) || ((size_q == 2'b11) && (addr_q[2:0] != 3'b000));
  assign timeout = (TimeoutCycles != 0) && (cnt_q == CntLast);

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    gnt       = 1'b0;
    capture   = 1'b0;
    set_err   = 1'b0;
    mem_req_o = 1'b0;
    case (state_q)
      BR_IDLE: begin
        if (bypass_req_i.req) begin
          gnt     = 1'b1;
          capture = 1'b1;
          state_d = BR_ISSUE;
        end
      end
      BR_ISSUE: begin
        cnt_d = '0;
        if (reject) begin
          rdata_d = '1;
          set_err = 1'b1;
          state_d = BR_RESP;
        end else begin
          mem_req_o = 1'b1;
          if (mem_gnt_i) state_d = BR_WAIT;
        end
      end
      BR_WAIT: begin
        // A response arriving on the timeout cycle still wins.
        if (mem_rvalid_i) begin
          rdata_d = we_q ? 64'h0 : mem_rdata_i;
          state_d = BR_RESP;
        end else if (timeout) begin
          rdata_d = '1;
          set_err = 1'b1;
          state_d = BR_RESP;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BR_RESP: begin
        rdata_d = '0;
        state_d = BR_IDLE;
      end
      default: state_d = BR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BR_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      size_q  <= '0;
      id_q    <= '0;
      amo_q   <= AMO_NONE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_q | set_err;
      if (capture) begin
        addr_q  <= bypass_req_i.addr;
        wdata_q <= bypass_req_i.wdata;
        we_q    <= bypass_req_i.we;
        be_q    <= bypass_req_i.be;
        size_q  <= bypass_req_i.size;
        id_q    <= bypass_req_i.id;
        amo_q   <= bypass_req_i.amo;
      end
    end
  end

  assign bypass_rsp_o.gnt   = gnt;
  assign bypass_rsp_o.valid = (state_q == BR_RESP);
  assign bypass_rsp_o.rdata = (state_q == BR_RESP) ? rdata_q : 64'h0;

  assign mem_addr_o  = {addr_q[63:3], 3'b000};
  assign mem_we_o    = we_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;
  assign err_o       = err_q;

  assign dbg_o.state = state_q;
  assign dbg_o.id    = id_q;

endmodule
